// File: rtl/snake_pkg.sv
// Shared types, constants and helpers for the two-player snake engine.
// Grid-edge behaviour of step() depends on the optional WRAP_EN macro.
package snake_pkg;

    localparam int POS_W = 10;
    localparam logic [POS_W-1:0] EMPTY_POS = 10'h3FF;
    localparam logic [4:0] GRID_MAX = 5'd31;
    localparam logic [POS_W-1:0] LFSR_SEED = 10'h001;
    localparam logic [POS_W-1:0] LFSR_TAPS = 10'h081;

    typedef enum logic [3:0] {
        DIR_LEFT  = 4'b0001,
        DIR_RIGHT = 4'b0010,
        DIR_UP    = 4'b0100,
        DIR_DOWN  = 4'b1000
    } dir_e;

    typedef struct packed {
        logic             off;
        logic [POS_W-1:0] pos;
    } step_t;

    // Head moved one cell; off flags leaving the grid (never set when wrapping).
    function automatic step_t step(input logic [POS_W-1:0] pos, input dir_e dir);
        step_t r;
        logic [4:0] x;
        logic [4:0] y;
        x = pos[4:0];
        y = pos[9:5];
        r.off = 1'b0;
        case (dir)
            DIR_LEFT:  begin r.off = (x == 5'd0);     x = x - 5'd1; end
            DIR_RIGHT: begin r.off = (x == GRID_MAX); x = x + 5'd1; end
            DIR_UP:    begin r.off = (y == 5'd0);     y = y - 5'd1; end
            DIR_DOWN:  begin r.off = (y == GRID_MAX); y = y + 5'd1; end
            default:   r.off = 1'b0;
        endcase
`ifdef WRAP_EN
        r.off = 1'b0;
`else
        r.off = r.off;
`endif
        r.pos = {y, x};
        return r;
    endfunction

    function automatic dir_e opposite(input dir_e d);
        case (d)
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            default:   return DIR_LEFT;
        endcase
    endfunction

    // Galois form of x^10 + x^7 + 1, shifting toward the MSB.
    function automatic logic [POS_W-1:0] lfsr_next(input logic [POS_W-1:0] v);
        return {v[8:0], 1'b0} ^ (v[9] ? LFSR_TAPS : 10'h000);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-tick divider: counts clk_raw cycles 0..div_num-1 and emits a one-cycle
// registered tick on each wrap; hold freezes the count, clear restarts it.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int div_num = 12500
) (
    input  logic clk_raw,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CW = (div_num > 1) ? $clog2(div_num) : 1;
    localparam logic [CW-1:0] LAST = CW'(div_num - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter and tick pulse.
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (hold) begin
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/snake_core.sv
// Two-player snake engine on a 32x32 grid. Define WRAP_EN for a toroidal grid;
// by default stepping off the grid counts as a collision.
module snake_core
    import snake_pkg::*;
#(
    parameter int max_len         = 31,
    parameter int max_len_bit_len = 5,
    parameter int clk_div_num     = 12500,
    parameter int init_score1     = 2,
    parameter int init_score2     = 2,
    parameter logic [9:0] init_food1 = 10'h008,
    parameter logic [9:0] init_food2 = 10'h031,
    parameter logic [(max_len+1)*10-1:0] init_snake1 = {{(max_len-1){10'h3FF}}, 10'h000, 10'h001},
    parameter logic [(max_len+1)*10-1:0] init_snake2 = {{(max_len-1){10'h3FF}}, 10'h040, 10'h021}
) (
    input  logic                         clk_raw,
    input  logic                         rst,
    input  logic [12:0]                  keystroke,
    output logic [(max_len+1)*10-1:0]    snake1,
    output logic [(max_len+1)*10-1:0]    snake2,
    output logic [9:0]                   food1,
    output logic [9:0]                   food2,
    output logic [max_len_bit_len:0]     score1,
    output logic [max_len_bit_len:0]     score2,
    output logic                         over1,
    output logic                         over2
);

    localparam int LW = max_len_bit_len + 1;

    logic [POS_W-1:0] body_r [2][max_len+1];
    logic [LW-1:0]    len_r  [2];
    logic [POS_W-1:0] food_r [2];
    logic             over_r [2];
    dir_e             dir_r  [2];
    logic [POS_W-1:0] lfsr_r;
    logic             key8_r;

    logic             tick_s;
    logic             hold_s;
    logic             restart_s;
    logic             unused_keys_s;
    logic [3:0]       key_s  [2];
    logic             turn_s [2];
    step_t            st_s   [2];
    logic             hit_s  [2];
    logic             eat_s  [2];
    logic             grow_s [2];

    function automatic logic [POS_W-1:0] init_seg(input int s, input int i);
        if (s == 0) return init_snake1[i*POS_W +: POS_W];
        else        return init_snake2[i*POS_W +: POS_W];
    endfunction

    function automatic logic [LW-1:0] init_len(input int s);
        return (s == 0) ? LW'(init_score1) : LW'(init_score2);
    endfunction

    function automatic logic [POS_W-1:0] init_food(input int s);
        return (s == 0) ? init_food1 : init_food2;
    endfunction

    assign hold_s        = ~keystroke[12] | keystroke[9];
    assign restart_s     = keystroke[8] & ~key8_r;
    assign unused_keys_s = ^keystroke[11:10];

    snake_tick_gen #(.div_num(clk_div_num)) u_tick (
        .clk_raw (clk_raw),
        .rst     (rst),
        .clear   (restart_s),
        .hold    (hold_s),
        .tick    (tick_s)
    );

    // Restart edge detector and food LFSR.
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            key8_r <= 1'b0;
            lfsr_r <= LFSR_SEED;
        end else begin
            key8_r <= keystroke[8];
            lfsr_r <= restart_s ? LFSR_SEED : lfsr_next(lfsr_r);
        end
    end

    // Accept a one-hot key unless it would turn the snake back on itself.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            key_s[s]  = keystroke[4*s +: 4];
            turn_s[s] = $onehot(key_s[s]) && (key_s[s] != opposite(dir_r[s]));
        end
    end

    // Latched steering direction.
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) dir_r[s] <= DIR_RIGHT;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (restart_s)      dir_r[s] <= DIR_RIGHT;
                else if (turn_s[s]) dir_r[s] <= dir_e'(key_s[s]);
            end
        end
    end

    // Next heads, collision and eating decisions; own tail is excluded since it vacates.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            st_s[s] = step(body_r[s][0], dir_r[s]);
        end
        for (int s = 0; s < 2; s++) begin
            int o;
            o = 1 - s;
            hit_s[s] = st_s[s].off;
            for (int i = 0; i <= max_len; i++) begin
                hit_s[s] = hit_s[s]
                         | ((i < int'(len_r[s]) - 1) && (st_s[s].pos == body_r[s][i]))
                         | ((i < int'(len_r[o]))     && (st_s[s].pos == body_r[o][i]));
            end
            hit_s[s] = hit_s[s] | (!over_r[o] && !st_s[o].off && (st_s[s].pos == st_s[o].pos));
            eat_s[s]  = (st_s[s].pos == food_r[s]);
            grow_s[s] = eat_s[s] && (len_r[s] <= LW'(max_len));
        end
    end

    // Snake bodies, lengths, foods and game-over flags.
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i <= max_len; i++) body_r[s][i] <= init_seg(s, i);
                len_r[s]  <= init_len(s);
                food_r[s] <= init_food(s);
                over_r[s] <= 1'b0;
            end
        end else if (restart_s) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i <= max_len; i++) body_r[s][i] <= init_seg(s, i);
                len_r[s]  <= init_len(s);
                food_r[s] <= init_food(s);
                over_r[s] <= 1'b0;
            end
        end else if (tick_s) begin
            for (int s = 0; s < 2; s++) begin
                if (!over_r[s]) begin
                    if (hit_s[s]) begin
                        over_r[s] <= 1'b1;
                    end else begin
                        body_r[s][0] <= st_s[s].pos;
                        for (int i = 1; i <= max_len; i++) begin
                            if ((i == int'(len_r[s])) && !grow_s[s]) body_r[s][i] <= EMPTY_POS;
                            else                                     body_r[s][i] <= body_r[s][i-1];
                        end
                        if (eat_s[s])  food_r[s] <= lfsr_r;
                        if (grow_s[s]) len_r[s]  <= len_r[s] + LW'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g <= max_len; g++) begin : g_pack
        assign snake1[g*POS_W +: POS_W] = body_r[0][g];
        assign snake2[g*POS_W +: POS_W] = body_r[1][g];
    end

    assign food1  = food_r[0];
    assign food2  = food_r[1];
    assign score1 = len_r[0];
    assign score2 = len_r[1];
    assign over1  = over_r[0];
    assign over2  = over_r[1];

endmodule

// File: tb/tb_snake_core.sv
// Directed bench for snake_core: three engines with different start bodies
// share clock, reset and keys; each task checks the engine it targets.
module tb_snake_core;

    localparam int DIV = 8;
    localparam int BW  = 320;
    localparam logic [BW-1:0] INIT1   = {{30{10'h3FF}}, 10'h000, 10'h001};
    localparam logic [BW-1:0] INIT2   = {{30{10'h3FF}}, 10'h040, 10'h021};
    localparam logic [BW-1:0] SELF1   = {{27{10'h3FF}}, 10'h10C, 10'h10D, 10'h10E, 10'h12E, 10'h12D};
    localparam logic [BW-1:0] EDGE1   = {{30{10'h3FF}}, 10'h01E, 10'h01F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] keystroke = 13'h0000;

    logic [BW-1:0] s1_a, s2_a, s1_s, s2_s, s1_e, s2_e;
    logic [9:0]    f1_a, f2_a, f1_s, f2_s, f1_e, f2_e;
    logic [5:0]    c1_a, c2_a, c1_s, c2_s, c1_e, c2_e;
    logic          o1_a, o2_a, o1_s, o2_s, o1_e, o2_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_core #(.clk_div_num(DIV)) u_a (
        .clk_raw(clk), .rst(rst), .keystroke(keystroke),
        .snake1(s1_a), .snake2(s2_a), .food1(f1_a), .food2(f2_a),
        .score1(c1_a), .score2(c2_a), .over1(o1_a), .over2(o2_a)
    );

    snake_core #(.clk_div_num(DIV), .init_score1(5), .init_snake1(SELF1)) u_s (
        .clk_raw(clk), .rst(rst), .keystroke(keystroke),
        .snake1(s1_s), .snake2(s2_s), .food1(f1_s), .food2(f2_s),
        .score1(c1_s), .score2(c2_s), .over1(o1_s), .over2(o2_s)
    );

    snake_core #(.clk_div_num(DIV), .init_snake1(EDGE1)) u_e (
        .clk_raw(clk), .rst(rst), .keystroke(keystroke),
        .snake1(s1_e), .snake2(s2_e), .food1(f1_e), .food2(f2_e),
        .score1(c1_e), .score2(c2_e), .over1(o1_e), .over2(o2_e)
    );

    // Sampling points sit half a tick after each board update.
    task automatic do_reset(input logic [12:0] k);
        rst = 1'b1;
        keystroke = k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (DIV/2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n*DIV) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(13'h0000);
        checks++; if (s1_a !== INIT1) begin errors++; $display("FAIL reset_snake1 got %h exp %h", s1_a, INIT1); end
        checks++; if (s2_a !== INIT2) begin errors++; $display("FAIL reset_snake2 got %h exp %h", s2_a, INIT2); end
        checks++; if (f1_a !== 10'h008) begin errors++; $display("FAIL reset_food1 got %h exp 008", f1_a); end
        checks++; if (f2_a !== 10'h031) begin errors++; $display("FAIL reset_food2 got %h exp 031", f2_a); end
        checks++; if (c1_a !== 6'd2 || c2_a !== 6'd2) begin errors++; $display("FAIL reset_scores got %0d/%0d exp 2/2", c1_a, c2_a); end
        checks++; if (o1_a !== 1'b0 || o2_a !== 1'b0) begin errors++; $display("FAIL reset_over got %b%b exp 00", o1_a, o2_a); end
        checks++; if (c1_s !== 6'd5) begin errors++; $display("FAIL reset_score_self got %0d exp 5", c1_s); end
    endtask

    task automatic test_food;
        do_reset(13'h1022);
        ticks(6);
        checks++; if (c1_a !== 6'd2 || s1_a[9:0] !== 10'h007) begin errors++; $display("FAIL food_before got score %0d head %h exp 2 007", c1_a, s1_a[9:0]); end
        ticks(1);
        checks++; if (c1_a !== 6'd3) begin errors++; $display("FAIL food_score1 got %0d exp 3", c1_a); end
        checks++; if (s1_a[39:0] !== {10'h3FF, 10'h006, 10'h007, 10'h008}) begin errors++; $display("FAIL food_body1 got %h exp 3ff006007008 packed", s1_a[39:0]); end
        checks++; if (f1_a === 10'h008) begin errors++; $display("FAIL food_respawn got %h exp not 008", f1_a); end
        ticks(9);
        checks++; if (c2_a !== 6'd3) begin errors++; $display("FAIL food_score2 got %0d exp 3", c2_a); end
        checks++; if (s2_a[9:0] !== 10'h031) begin errors++; $display("FAIL food_head2 got %h exp 031", s2_a[9:0]); end
    endtask

    task automatic test_self_hit;
        do_reset(13'h1004);
        ticks(1);
        checks++; if (o1_s !== 1'b1) begin errors++; $display("FAIL self_over got %b exp 1", o1_s); end
        checks++; if (s1_s !== SELF1) begin errors++; $display("FAIL self_body got %h exp %h", s1_s, SELF1); end
    endtask

    task automatic test_snake_hit;
        do_reset(13'h1042);
        ticks(1);
        checks++; if (o2_a !== 1'b1 || o1_a !== 1'b0) begin errors++; $display("FAIL hit_over got %b%b exp 01", o1_a, o2_a); end
        checks++; if (s2_a !== INIT2) begin errors++; $display("FAIL hit_body2 got %h exp %h", s2_a, INIT2); end
        checks++; if (s1_a[29:0] !== {10'h3FF, 10'h001, 10'h002}) begin errors++; $display("FAIL hit_body1 got %h exp 3ff001002 packed", s1_a[29:0]); end
        ticks(2);
        checks++; if (s1_a[9:0] !== 10'h004 || o1_a !== 1'b0) begin errors++; $display("FAIL hit_move1 got head %h over %b exp 004 0", s1_a[9:0], o1_a); end
    endtask

    task automatic test_restart;
        checks++; if (o2_a !== 1'b1 || o1_s !== 1'b1) begin errors++; $display("FAIL restart_pre got %b%b exp 11", o2_a, o1_s); end
        keystroke = 13'h0100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        keystroke = 13'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o1_a !== 1'b0 || o2_a !== 1'b0) begin errors++; $display("FAIL restart_over_a got %b%b exp 00", o1_a, o2_a); end
        checks++; if (s1_a !== INIT1) begin errors++; $display("FAIL restart_snake1 got %h exp %h", s1_a, INIT1); end
        checks++; if (s2_a !== INIT2) begin errors++; $display("FAIL restart_snake2 got %h exp %h", s2_a, INIT2); end
        checks++; if (f1_a !== 10'h008 || f2_a !== 10'h031) begin errors++; $display("FAIL restart_food got %h %h exp 008 031", f1_a, f2_a); end
        checks++; if (c1_a !== 6'd2 || c2_a !== 6'd2) begin errors++; $display("FAIL restart_scores got %0d/%0d exp 2/2", c1_a, c2_a); end
        checks++; if (o1_s !== 1'b0) begin errors++; $display("FAIL restart_over_s got %b exp 0", o1_s); end
        checks++; if (s1_s !== SELF1 || c1_s !== 6'd5) begin errors++; $display("FAIL restart_self got %h len %0d exp %h len 5", s1_s, c1_s, SELF1); end
    endtask

    task automatic test_reverse;
        do_reset(13'h1002);
        ticks(2);
        checks++; if (s1_a[9:0] !== 10'h003) begin errors++; $display("FAIL rev_start got %h exp 003", s1_a[9:0]); end
        keystroke = 13'h1001;
        ticks(2);
        checks++; if (s1_a[9:0] !== 10'h005) begin errors++; $display("FAIL rev_ignored got %h exp 005", s1_a[9:0]); end
        keystroke = 13'h1003;
        ticks(1);
        checks++; if (s1_a[9:0] !== 10'h006) begin errors++; $display("FAIL rev_multikey got %h exp 006", s1_a[9:0]); end
    endtask

    task automatic test_pause;
        do_reset(13'h1202);
        repeat (5*DIV) @(posedge clk);
        @(negedge clk);
        checks++; if (s1_a !== INIT1) begin errors++; $display("FAIL pause_hold got %h exp %h", s1_a, INIT1); end
        keystroke = 13'h0002;
        repeat (5*DIV) @(posedge clk);
        @(negedge clk);
        checks++; if (s1_a !== INIT1) begin errors++; $display("FAIL run_off_hold got %h exp %h", s1_a, INIT1); end
        keystroke = 13'h1002;
        repeat (DIV + DIV/2) @(posedge clk);
        @(negedge clk);
        checks++; if (s1_a[9:0] !== 10'h002) begin errors++; $display("FAIL resume got %h exp 002", s1_a[9:0]); end
    endtask

    task automatic test_edge;
        do_reset(13'h1002);
        ticks(1);
`ifdef WRAP_EN
        checks++; if (o1_e !== 1'b0) begin errors++; $display("FAIL edge_over got %b exp 0", o1_e); end
        checks++; if (s1_e[19:0] !== {10'h01F, 10'h000}) begin errors++; $display("FAIL edge_wrap got %h exp 07c00", s1_e[19:0]); end
`else
        checks++; if (o1_e !== 1'b1) begin errors++; $display("FAIL edge_over got %b exp 1", o1_e); end
        checks++; if (s1_e !== EDGE1) begin errors++; $display("FAIL edge_body got %h exp %h", s1_e, EDGE1); end
`endif
    endtask

    initial begin
        test_reset;
        test_food;
        test_self_hit;
        test_snake_hit;
        test_restart;
        test_reverse;
        test_pause;
        test_edge;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
